// File: rtl/pixel_sink_pkg.sv
// rtl/pixel_sink_pkg.sv - shared constants, colour codes and address helper for pixel_sink
package pixel_sink_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int OFFSCREEN_X = 160;
  localparam int ADDR_W      = 15;
  localparam int COLOUR_W    = 3;
  localparam int ENTRY_W     = ADDR_W + COLOUR_W;

  typedef enum logic [COLOUR_W-1:0] {
    BLACK   = 3'b000,
    BLUE    = 3'b001,
    GREEN   = 3'b010,
    CYAN    = 3'b011,
    RED     = 3'b100,
    MAGENTA = 3'b101,
    YELLOW  = 3'b110,
    WHITE   = 3'b111
  } colour_e;

  // y*160 + x as two shifts and an add, truncated to the framebuffer width
  function automatic logic [ADDR_W-1:0] linear_addr(input logic [10:0] x, input logic [10:0] y);
    logic [ADDR_W-1:0] w_ye;
    logic [ADDR_W-1:0] w_xe;
    w_ye = ADDR_W'(y);
    w_xe = ADDR_W'(x);
    return (w_ye << 7) + (w_ye << 5) + w_xe;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous FIFO for buffered pixel entries
// Pointers carry one extra bit so full and empty are distinguishable.
module pixel_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pixel_sink.sv
// rtl/pixel_sink.sv - pixel-draw receiver: clip, linearise, buffer, drain to framebuffer RAM
// Optional macro PIXEL_SINK_DEDUP_EN suppresses pushes identical to the last pushed entry.
module pixel_sink
  import pixel_sink_pkg::*;
#(
  parameter int SCREEN_W   = pixel_sink_pkg::SCREEN_W,
  parameter int SCREEN_H   = pixel_sink_pkg::SCREEN_H,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] in_x,
  input  logic [10:0] in_y,
  input  logic [2:0]  in_colour,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        overflow,
  output logic [15:0] pixel_count
);

  localparam logic [10:0] X_LIM = 11'(SCREEN_W);
  localparam logic [10:0] Y_LIM = 11'(SCREEN_H);

  logic                r_s1_valid;
  logic [ADDR_W-1:0]   r_s1_addr;
  logic [COLOUR_W-1:0] r_s1_colour;
  logic                r_overflow;
  logic [15:0]         r_pixel_count;

  logic [ENTRY_W-1:0]  w_entry;
  logic [ENTRY_W-1:0]  w_dout;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_colour <= '0;
    end else begin
      r_s1_valid  <= (in_x < X_LIM) && (in_y < Y_LIM);
      r_s1_addr   <= linear_addr(in_x, in_y);
      r_s1_colour <= in_colour;
    end
  end

  assign w_entry  = {r_s1_addr, r_s1_colour};
  assign w_pop    = !w_empty && mem_ready;
  assign w_accept = !w_full || w_pop;

`ifdef PIXEL_SINK_DEDUP_EN
  logic               r_last_valid;
  logic [ENTRY_W-1:0] r_last_entry;

  assign w_push = r_s1_valid && !(r_last_valid && (r_last_entry == w_entry));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_valid <= 1'b0;
      r_last_entry <= '0;
    end else if (w_push && w_accept) begin
      r_last_valid <= 1'b1;
      r_last_entry <= w_entry;
    end
  end
`else
  assign w_push = r_s1_valid;
`endif

  pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_entry),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow    <= 1'b0;
      r_pixel_count <= '0;
    end else begin
      if (w_push && !w_accept) r_overflow <= 1'b1;
      if (w_pop)               r_pixel_count <= r_pixel_count + 16'd1;
    end
  end

  // Head is masked while empty so the RAM port shows zeros rather than stale storage
  assign mem_we      = !w_empty;
  assign mem_addr    = w_empty ? '0 : w_dout[ENTRY_W-1:COLOUR_W];
  assign mem_data    = w_empty ? '0 : w_dout[COLOUR_W-1:0];
  assign overflow    = r_overflow;
  assign pixel_count = r_pixel_count;

endmodule

// File: tb/tb_pixel_sink.sv
// tb/tb_pixel_sink.sv - scoreboard bench for pixel_sink
module tb_pixel_sink;
  import pixel_sink_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] in_x = 11'd160;
  logic [10:0] in_y = 11'd0;
  logic [2:0]  in_colour = 3'd0;
  logic        mem_ready = 1'b1;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        overflow;
  logic [15:0] pixel_count;

  int          compared = 0;
  int          mismatched = 0;
  int          exp_total = 0;
  logic        last_we;
  logic [17:0] sb_q [$];

  pixel_sink #(.SCREEN_W(160), .SCREEN_H(120), .FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_colour   (in_colour),
    .mem_ready   (mem_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .overflow    (overflow),
    .pixel_count (pixel_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, score any write that completes at the coming posedge
  task automatic step(input int x, input int y, input logic [2:0] c, input logic rdy, input bit want);
    logic [17:0] e;
    @(negedge clock);
    in_x      = 11'(x);
    in_y      = 11'(y);
    in_colour = c;
    mem_ready = rdy;
    if (want) begin
      sb_q.push_back({15'(y * 160 + x), c});
      exp_total++;
    end
    #1;
    last_we = mem_we;
    if (mem_we && mem_ready) begin
      check("write_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("mem_addr", 32'(mem_addr), 32'(e[17:3]));
        check("mem_data", 32'(mem_data), 32'(e[2:0]));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(OFFSCREEN_X, 0, BLACK, rdy, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_count", 32'(pixel_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Sentinel held: nothing written
    repeat (20) idle(1'b1);
    check("idle_we", 32'(last_we), 32'd0);
    check("idle_count", 32'(pixel_count), 32'd0);
    check("idle_overflow", 32'(overflow), 32'd0);

    // Single pixel latency
    step(5, 2, RED, 1'b1, 1'b1);
    idle(1'b1);
    check("lat_we_edge1", 32'(last_we), 32'd0);
    idle(1'b1);
    check("lat_we_edge2", 32'(last_we), 32'd1);
    idle(1'b1);
    check("single_count", 32'(pixel_count), 32'd1);

    // Corners: two visible, two off-screen
    step(0, 0, WHITE, 1'b1, 1'b1);
    step(159, 119, CYAN, 1'b1, 1'b1);
    step(160, 0, YELLOW, 1'b1, 1'b0);
    step(0, 120, BLUE, 1'b1, 1'b0);
    repeat (4) idle(1'b1);
    check("corner_drained", 32'(sb_q.size()), 32'd0);
    check("corner_count", 32'(pixel_count), 32'(exp_total));
    check("corner_overflow", 32'(overflow), 32'd0);

    // Stalled RAM: four held, two dropped
    for (int i = 0; i < 6; i++) step(10 + i, 20, 3'(i + 1), 1'b0, i < 4);
    repeat (2) idle(1'b0);
    check("stall_overflow", 32'(overflow), 32'd1);
    check("stall_we", 32'(last_we), 32'd1);
    repeat (6) idle(1'b1);
    check("stall_drained", 32'(sb_q.size()), 32'd0);
    check("stall_count", 32'(pixel_count), 32'(exp_total));
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset with three entries buffered
    for (int i = 0; i < 3; i++) step(40 + i, 7, GREEN, 1'b0, 1'b1);
    repeat (2) idle(1'b0);
    check("pre_reset_we", 32'(last_we), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("async_reset_we", 32'(mem_we), 32'd0);
    check("async_reset_count", 32'(pixel_count), 32'd0);
    check("async_reset_overflow", 32'(overflow), 32'd0);
    sb_q.delete();
    exp_total = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) idle(1'b1);
    check("post_reset_queue", 32'(sb_q.size()), 32'd0);
    check("post_reset_count", 32'(pixel_count), 32'd0);

    // Full-rate raster
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        step(x, y, 3'((x + y) % 8), 1'b1, 1'b1);
    repeat (4) idle(1'b1);
    check("raster_drained", 32'(sb_q.size()), 32'd0);
    check("raster_count", 32'(pixel_count), 32'd19200);
    check("raster_overflow", 32'(overflow), 32'd0);

    // Repeated coordinate
    for (int i = 0; i < 10; i++) begin
`ifdef PIXEL_SINK_DEDUP_EN
      step(3, 3, GREEN, 1'b1, i == 0);
`else
      step(3, 3, GREEN, 1'b1, 1'b1);
`endif
    end
    repeat (4) idle(1'b1);
    check("repeat_drained", 32'(sb_q.size()), 32'd0);
    check("repeat_count", 32'(pixel_count), 32'(exp_total[15:0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
